// File: rtl/wbarbiter_n.sv
// wbarbiter_n: N-master to 1-slave pipelined Wishbone arbiter with back-pressure and bus watchdog
// ports: i_clk/i_rst clock and sync reset; i_mcyc/i_mstb/i_mwe/i_madr/i_mdat/i_msel per-master requests,
// o_mstall/o_mack/o_merr per-master responses; o_cyc/o_stb/o_we/o_adr/o_dat/o_sel slave request,
// i_stall/i_ack/i_err slave responses
module wbarbiter_n #(
  parameter int NM = 4,
  parameter int AW = 19,
  parameter int DW = 32,
  parameter string METHOD = "ROUND_ROBIN",
  parameter int LGPEND = 4,
  parameter int TIMEOUT = 1023,
  parameter bit OPT_ZERO_ON_IDLE = 1'b0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NM-1:0]        i_mcyc,
  input  logic [NM-1:0]        i_mstb,
  input  logic [NM-1:0]        i_mwe,
  input  logic [NM*AW-1:0]     i_madr,
  input  logic [NM*DW-1:0]     i_mdat,
  input  logic [NM*DW/8-1:0]   i_msel,
  output logic [NM-1:0]        o_mstall,
  output logic [NM-1:0]        o_mack,
  output logic [NM-1:0]        o_merr,
  output logic                 o_cyc,
  output logic                 o_stb,
  output logic                 o_we,
  output logic [AW-1:0]        o_adr,
  output logic [DW-1:0]        o_dat,
  output logic [DW/8-1:0]      o_sel,
  input  logic                 i_stall,
  input  logic                 i_ack,
  input  logic                 i_err
);
  localparam int OW = $clog2(NM);
  localparam int SW = DW / 8;
  localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam bit RR = METHOD != "PRIORITY";
  localparam bit WD = TIMEOUT > 0;
  logic r_grant, r_abort, full, accept, busy, wd_err, live;
  logic [OW-1:0] r_owner, pick;
  logic [NM-1:0] own;
  logic [LGPEND-1:0] pending;
  logic [TW-1:0] timer;
  // i-th candidate in search order; RR starts just past the previous owner
  function automatic logic [OW-1:0] slot(input logic [OW-1:0] base, input int i);
    return OW'(RR ? (int'(base) + i) % NM : i - 1);
  endfunction
  // scan from the lowest-preference candidate up so the preferred one wins last
  always_comb begin
    pick = r_owner;
    for (int i = NM; i >= 1; i--)
      if (i_mcyc[slot(r_owner, i)]) pick = slot(r_owner, i);
  end
  always_comb begin
    own = r_grant ? NM'(1) << r_owner : '0;
    o_cyc = r_grant & i_mcyc[r_owner] & !r_abort;
    full = pending == '1;
    o_stb = o_cyc & i_mstb[r_owner] & !full;
    accept = o_stb & !i_stall;
    busy = (pending != '0) | (o_stb & i_stall);
    wd_err = WD && o_cyc && busy && timer == TW'(TIMEOUT - 1);
    live = OPT_ZERO_ON_IDLE ? o_cyc : 1'b1;
    o_we = live & i_mwe[r_owner];
    o_adr = live ? i_madr[int'(r_owner)*AW +: AW] : '0;
    o_dat = live ? i_mdat[int'(r_owner)*DW +: DW] : '0;
    o_sel = live ? i_msel[int'(r_owner)*SW +: SW] : '0;
    o_mstall = ~own | {NM{i_stall | full | r_abort}};
    o_mack = own & {NM{i_ack & o_cyc}};
    o_merr = own & {NM{(i_err & o_cyc) | wd_err}};
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_grant <= 1'b0;
      r_owner <= '0;
      r_abort <= 1'b0;
      pending <= '0;
      timer <= '0;
    end else begin
      if (!r_grant) begin
        r_grant <= |i_mcyc;
        if (|i_mcyc) r_owner <= pick;
      end else if (!i_mcyc[r_owner]) begin
        r_grant <= 1'b0;
        r_abort <= 1'b0;
      end else if (wd_err) r_abort <= 1'b1;
      pending <= (!o_cyc || i_err || wd_err) ? '0 : pending + LGPEND'(accept) - LGPEND'(i_ack);
      timer <= (!WD || !o_cyc || i_ack || accept || !busy || wd_err) ? '0 : timer + TW'(1);
    end
  end
endmodule

// File: tb/tb_wbarbiter_n.sv
// tb_wbarbiter_n: directed scoreboard bench for wbarbiter_n (round-robin and priority instances)
module tb_wbarbiter_n;
  localparam int NM = 4;
  localparam int AW = 19;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [NM-1:0] mcyc = '0, mstb = '0, mwe = '0, pcyc = '0;
  logic [NM*AW-1:0] madr = '0;
  logic [NM*DW-1:0] mdat = '0;
  logic [NM*SW-1:0] msel = '0;
  logic stall = 1'b0, ack = 1'b0, err = 1'b0;
  logic [NM-1:0] r_mstall, r_mack, r_merr, p_mstall, p_mack, p_merr;
  logic r_cyc, r_stb, r_we, p_cyc, p_stb, p_we;
  logic [AW-1:0] r_adr, p_adr;
  logic [DW-1:0] r_dat, p_dat;
  logic [SW-1:0] r_sel, p_sel;
  int checks = 0;
  int errors = 0;
  logic [55:0] txq[$];
  logic [7:0] rspq[$];
  wbarbiter_n #(.NM(NM), .AW(AW), .DW(DW), .METHOD("ROUND_ROBIN"), .LGPEND(2), .TIMEOUT(8),
    .OPT_ZERO_ON_IDLE(1'b1)) u_rr (
    .i_clk(clk), .i_rst(rst), .i_mcyc(mcyc), .i_mstb(mstb), .i_mwe(mwe), .i_madr(madr),
    .i_mdat(mdat), .i_msel(msel), .o_mstall(r_mstall), .o_mack(r_mack), .o_merr(r_merr),
    .o_cyc(r_cyc), .o_stb(r_stb), .o_we(r_we), .o_adr(r_adr), .o_dat(r_dat), .o_sel(r_sel),
    .i_stall(stall), .i_ack(ack), .i_err(err));
  wbarbiter_n #(.NM(NM), .AW(AW), .DW(DW), .METHOD("PRIORITY"), .LGPEND(4), .TIMEOUT(0),
    .OPT_ZERO_ON_IDLE(1'b0)) u_pr (
    .i_clk(clk), .i_rst(rst), .i_mcyc(pcyc), .i_mstb(4'b0000), .i_mwe(mwe), .i_madr(madr),
    .i_mdat(mdat), .i_msel(msel), .o_mstall(p_mstall), .o_mack(p_mack), .o_merr(p_merr),
    .o_cyc(p_cyc), .o_stb(p_stb), .o_we(p_we), .o_adr(p_adr), .o_dat(p_dat), .o_sel(p_sel),
    .i_stall(1'b0), .i_ack(1'b0), .i_err(1'b0));
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic next();
    @(posedge clk);
    #1;
  endtask
  task automatic neg();
    @(negedge clk);
  endtask
  task automatic beat(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic we, input logic [SW-1:0] s, input bit push);
    madr[k*AW +: AW] = a;
    mdat[k*DW +: DW] = d;
    msel[k*SW +: SW] = s;
    mwe[k] = we;
    mstb[k] = 1'b1;
    if (push) txq.push_back({we, s, a, d});
  endtask
  task automatic rsp(input logic [NM-1:0] a, input logic [NM-1:0] e);
    rspq.push_back({a, e});
  endtask
  always @(negedge clk) begin
    if (r_cyc && r_stb && !stall) begin
      if (txq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_extra: got %0h expected none", {r_we, r_sel, r_adr, r_dat});
      end else chk("tx", {r_we, r_sel, r_adr, r_dat}, txq.pop_front());
    end
    if (|r_mack || |r_merr) begin
      if (rspq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_extra: got %0h expected none", {r_mack, r_merr});
      end else chk("rsp", {r_mack, r_merr}, rspq.pop_front());
    end
  end
  initial begin
    next();
    next();
    neg();
    chk("rst_cyc", r_cyc, 0);
    chk("rst_stall", r_mstall, 4'hf);
    chk("rst_ack_err", {r_mack, r_merr}, 0);
    chk("rst_adr_zero", r_adr, 0);
    chk("rst_pr_stall", p_mstall, 4'hf);
    next();
    rst = 1'b0;
    mcyc = 4'b0110;
    neg();
    chk("rr_req_stall", r_mstall, 4'hf);
    chk("rr_req_cyc", r_cyc, 0);
    next();
    beat(1, 19'h01234, 32'hdead0001, 1'b1, 4'hf, 1'b1);
    neg();
    chk("rr_grant1_cyc", r_cyc, 1);
    chk("rr_grant1_stall", r_mstall, 4'b1101);
    next();
    mstb = '0;
    ack = 1'b1;
    rsp(4'b0010, 4'b0000);
    next();
    ack = 1'b0;
    mcyc = 4'b0100;
    neg();
    chk("rr_drop_cyc", r_cyc, 0);
    next();
    neg();
    chk("rr_idle_cyc", r_cyc, 0);
    chk("rr_idle_stall", r_mstall, 4'hf);
    next();
    neg();
    chk("rr_grant2_cyc", r_cyc, 1);
    chk("rr_grant2_stall", r_mstall, 4'b1011);
    next();
    mcyc = '0;
    next();
    pcyc = 4'b1000;
    next();
    pcyc = 4'b1101;
    neg();
    chk("pr_own3", p_mstall, 4'b0111);
    chk("pr_own3_cyc", p_cyc, 1);
    repeat (2) begin
      next();
      neg();
      chk("pr_keep3", p_mstall, 4'b0111);
    end
    next();
    pcyc = 4'b0101;
    neg();
    chk("pr_drop", p_cyc, 0);
    next();
    neg();
    chk("pr_idle", p_mstall, 4'hf);
    next();
    neg();
    chk("pr_win0", p_mstall, 4'b1110);
    chk("pr_win0_cyc", p_cyc, 1);
    next();
    pcyc = '0;
    mcyc = 4'b0001;
    next();
    beat(0, 19'h00100, 32'h00000011, 1'b0, 4'h1, 1'b1);
    neg();
    chk("lp_grant0", r_mstall, 4'b1110);
    next();
    beat(0, 19'h00101, 32'h00000022, 1'b1, 4'h3, 1'b1);
    next();
    beat(0, 19'h00102, 32'h00000033, 1'b1, 4'hc, 1'b1);
    next();
    beat(0, 19'h00103, 32'h00000044, 1'b1, 4'hf, 1'b0);
    neg();
    chk("lp_full_stall", r_mstall[0], 1);
    chk("lp_full_stb", r_stb, 0);
    next();
    ack = 1'b1;
    rsp(4'b0001, 4'b0000);
    neg();
    chk("lp_full_ack_stall", r_mstall[0], 1);
    next();
    ack = 1'b0;
    txq.push_back({1'b1, 4'hf, 19'h00103, 32'h00000044});
    neg();
    chk("lp_after_ack", r_mstall[0], 0);
    next();
    mstb = '0;
    ack = 1'b1;
    repeat (3) rsp(4'b0001, 4'b0000);
    next();
    next();
    next();
    ack = 1'b0;
    beat(0, 19'h00200, 32'h00000055, 1'b0, 4'hf, 1'b1);
    next();
    beat(0, 19'h00201, 32'h00000066, 1'b1, 4'hf, 1'b1);
    ack = 1'b1;
    rsp(4'b0001, 4'b0000);
    next();
    ack = 1'b0;
    beat(0, 19'h00202, 32'h00000077, 1'b1, 4'hf, 1'b1);
    neg();
    chk("ackstb_p2_stall", r_mstall[0], 0);
    next();
    beat(0, 19'h00203, 32'h00000078, 1'b1, 4'hf, 1'b1);
    neg();
    chk("ackstb_p3_stall", r_mstall[0], 0);
    next();
    beat(0, 19'h00204, 32'h00000079, 1'b0, 4'h5, 1'b0);
    err = 1'b1;
    rsp(4'b0000, 4'b0001);
    neg();
    chk("err_full_stall", r_mstall[0], 1);
    chk("err_owner_only", r_merr, 4'b0001);
    next();
    err = 1'b0;
    txq.push_back({1'b0, 4'h5, 19'h00204, 32'h00000079});
    neg();
    chk("err_cleared_stall", r_mstall[0], 0);
    next();
    mstb = '0;
    ack = 1'b1;
    rsp(4'b0001, 4'b0000);
    next();
    ack = 1'b0;
    next();
    beat(0, 19'h00300, 32'h00000088, 1'b0, 4'hf, 1'b1);
    rsp(4'b0000, 4'b0001);
    next();
    mstb = '0;
    neg();
    chk("wd_quiet", r_merr, 0);
    repeat (6) begin
      next();
      neg();
      chk("wd_quiet", r_merr, 0);
    end
    next();
    neg();
    chk("wd_fire", r_merr, 4'b0001);
    next();
    ack = 1'b1;
    neg();
    chk("wd_abort_cyc", r_cyc, 0);
    chk("wd_late_ack", r_mack, 0);
    chk("wd_abort_stall", r_mstall, 4'hf);
    next();
    ack = 1'b0;
    neg();
    chk("wd_abort_hold", r_cyc, 0);
    next();
    mcyc = '0;
    next();
    neg();
    chk("wd_release_stall", r_mstall, 4'hf);
    next();
    mcyc = 4'b1000;
    next();
    beat(3, 19'h00400, 32'h00000099, 1'b1, 4'hf, 1'b1);
    neg();
    chk("rst_grant3", r_mstall, 4'b0111);
    next();
    beat(3, 19'h00401, 32'h0000009a, 1'b1, 4'hf, 1'b1);
    next();
    beat(3, 19'h00402, 32'h0000009b, 1'b1, 4'hf, 1'b1);
    next();
    beat(3, 19'h00403, 32'h0000009c, 1'b1, 4'hf, 1'b0);
    rst = 1'b1;
    neg();
    chk("rst_pre_cyc", r_cyc, 1);
    chk("rst_pre_full", r_mstall, 4'hf);
    next();
    ack = 1'b1;
    neg();
    chk("rst_mid_cyc", r_cyc, 0);
    chk("rst_mid_stall", r_mstall, 4'hf);
    chk("rst_mid_ack", r_mack, 0);
    next();
    rst = 1'b0;
    ack = 1'b0;
    mcyc = '0;
    mstb = '0;
    repeat (3) next();
    neg();
    chk("txq_drained", txq.size(), 0);
    chk("rspq_drained", rspq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
